// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// requesters, with optional multi-byte message locking and a timeout on
// the transmitter's busy acknowledgement.
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 8,
  parameter  int BUSY_TIMEOUT = 16,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_input_data,
  output logic                          tx_input_data_valid,
  input  logic                          tx_output_ready,
  output logic [ID_W-1:0]               grant_id,
  output logic                          locked,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_last;
  logic [CNT_W-1:0] cnt;
  logic             cand_found;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  pos;

  // Pick the candidate: the lock owner only, or a rotating scan after the last winner
  always_comb begin
    cand_found = 1'b0;
    winner     = '0;
    pos        = '0;
    if (locked) begin
      cand_found = req_valid[grant_id];
      winner     = grant_id;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        pos = ID_W'((32'(rr_last) + 32'd1 + k) % 32'(NUM_REQ));
        if (!cand_found && req_valid[pos]) begin
          cand_found = 1'b1;
          winner     = pos;
        end
      end
    end
  end

  // One-hot accept strobe, only while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (state == IDLE && cand_found && !rst)
      req_ready[winner] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Main control FSM with registered transmitter-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      tx_input_data       <= '0;
      tx_input_data_valid <= 1'b0;
      grant_id            <= '0;
      locked              <= 1'b0;
      err_timeout         <= 1'b0;
      cnt                 <= '0;
      rr_last             <= ID_W'(NUM_REQ - 1);
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cand_found) begin
            tx_input_data       <= req_data[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
            tx_input_data_valid <= 1'b1;
            grant_id            <= winner;
            locked              <= ~req_last[winner];
            // pointer advances on unlocked accepts and on the lock-releasing byte
            if (!locked || req_last[winner])
              rr_last <= winner;
            state <= SEND;
          end
        end
        SEND: begin
          if (tx_output_ready) begin
            tx_input_data_valid <= 1'b0;
            cnt                 <= '0;
            state               <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!tx_output_ready) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            locked      <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_output_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model and
// per-requester byte queues.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    tx_input_data;
  logic             tx_input_data_valid;
  logic             tx_output_ready;
  logic [1:0]       grant_id;
  logic             locked;
  logic             busy;
  logic             err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_input_data(tx_input_data),
    .tx_input_data_valid(tx_input_data_valid),
    .tx_output_ready(tx_output_ready),
    .grant_id(grant_id),
    .locked(locked),
    .busy(busy),
    .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // requester byte queues: {last, data}
  logic [8:0] qmem [NR][32];
  int qwr [NR] = '{default: 0};
  int qrd [NR] = '{default: 0};

  // transmitter model controls
  int frame_len  = 5;
  bit never_drop = 1'b0;
  int tx_cnt     = 0;

  // logs filled by the driver/monitor process
  int         acc_log [256];
  int         acc_cnt = 0;
  logic [7:0] rx_log [256];
  int         rx_cnt = 0;
  logic       post_locked [256];
  logic [1:0] post_gid [256];
  int         post_cnt = 0;
  int         viol = 0;
  int         valid_cycles = 0;
  logic       acc_prev = 1'b0;
  logic [NR-1:0] acc;
  logic       hs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] d);
    qmem[r][qwr[r] % 32] = {last, d};
    qwr[r]++;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_acc(input string tag, input int target, input int budget);
    int t;
    t = 0;
    while (acc_cnt < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    check(tag, 32'(acc_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || !tx_output_ready) && t < budget);
    check(tag, 32'(!busy && tx_output_ready), 32'd1);
  endtask

  task automatic wait_ready_seen(input string tag, input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((req_valid & req_ready) == '0 && t < budget);
    check(tag, 32'((req_valid & req_ready) != '0), 32'd1);
  endtask

  // Requester driver, transmitter model and accept monitor
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_output_ready = 1'b1;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (acc_prev) begin
        post_locked[post_cnt] = locked;
        post_gid[post_cnt]    = grant_id;
        post_cnt++;
      end
      acc_prev = |acc;
      if (|acc) begin
        for (int i = 0; i < NR; i++)
          if (acc[i]) acc_log[acc_cnt] = i;
        acc_cnt++;
      end
      if ($countones(req_ready) > 1 || (busy && |req_ready)) viol++;
      if (tx_input_data_valid) valid_cycles++;
      hs = tx_input_data_valid && tx_output_ready && (tx_cnt == 0);
      if (hs) begin
        rx_log[rx_cnt] = tx_input_data;
        rx_cnt++;
      end
      @(posedge clk);
      #1;
      if (hs && !never_drop) begin
        tx_output_ready = 1'b0;
        tx_cnt = frame_len;
      end else if (tx_cnt > 1) begin
        tx_cnt--;
      end else if (tx_cnt == 1) begin
        tx_cnt = 0;
        tx_output_ready = 1'b1;
      end
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) qrd[i]++;
        if (qrd[i] != qwr[i]) begin
          req_valid[i]          = 1'b1;
          req_last[i]           = qmem[i][qrd[i] % 32][8];
          req_data[i*DW +: DW]  = qmem[i][qrd[i] % 32][7:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int a0, r0, base, busy_n, first_err, err_n;
    logic lock_at;

    // Reset and idle
    do_reset(3);
    base = valid_cycles;
    repeat (8) @(negedge clk);
    check("rst_valid",   32'(tx_input_data_valid), 32'd0);
    check("rst_data",    32'(tx_input_data), 32'h00);
    check("rst_ready",   32'(req_ready), 32'h0);
    check("rst_grant",   32'(grant_id), 32'd0);
    check("rst_locked",  32'(locked), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_err",     32'(err_timeout), 32'd0);
    check("idle_novalid", 32'(valid_cycles - base), 32'd0);

    // Single byte, long frame
    frame_len = 1000;
    do_reset(2);
    a0 = acc_cnt; r0 = rx_cnt;
    push(2, 1'b1, 8'hDF);
    wait_ready_seen("sb_accept_seen", 20);
    check("sb_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    check("sb_valid",  32'(tx_input_data_valid), 32'd1);
    check("sb_data",   32'(tx_input_data), 32'hDF);
    check("sb_grant",  32'(grant_id), 32'd2);
    check("sb_locked", 32'(locked), 32'd0);
    busy_n = busy ? 1 : 0;
    for (int t = 0; t < 1200 && busy; t++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    check("sb_busy_len", 32'(busy_n), 32'd1002);
    check("sb_acc_count", 32'(acc_cnt - a0), 32'd1);
    check("sb_rx", 32'(rx_log[r0]), 32'hDF);

    // Round robin with all requesters valid
    frame_len = 3;
    do_reset(2);
    a0 = acc_cnt; r0 = rx_cnt;
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < NR; i++)
        push(i, 1'b1, 8'(8'h10 + i));
    wait_acc("rr_done", a0 + 8, 400);
    wait_idle("rr_idle", 50);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("rr_order%0d", j), 32'(acc_log[a0 + j]), 32'(j % 4));
      check($sformatf("rr_byte%0d", j),  32'(rx_log[r0 + j]), 32'(8'h10 + (j % 4)));
    end

    // Message lock: requester 1 three bytes, requester 0 waiting
    do_reset(2);
    a0 = acc_cnt; r0 = rx_cnt;
    push(1, 1'b0, 8'hA0);
    push(1, 1'b0, 8'hA1);
    push(1, 1'b1, 8'hBF);
    wait_acc("lk_first", a0 + 1, 50);
    push(0, 1'b1, 8'h55);
    wait_acc("lk_done", a0 + 4, 400);
    wait_idle("lk_idle", 50);
    check("lk_ord0", 32'(acc_log[a0 + 0]), 32'd1);
    check("lk_ord1", 32'(acc_log[a0 + 1]), 32'd1);
    check("lk_ord2", 32'(acc_log[a0 + 2]), 32'd1);
    check("lk_ord3", 32'(acc_log[a0 + 3]), 32'd0);
    check("lk_rx0", 32'(rx_log[r0 + 0]), 32'hA0);
    check("lk_rx1", 32'(rx_log[r0 + 1]), 32'hA1);
    check("lk_rx2", 32'(rx_log[r0 + 2]), 32'hBF);
    check("lk_rx3", 32'(rx_log[r0 + 3]), 32'h55);
    check("lk_lock0", 32'(post_locked[a0 + 0]), 32'd1);
    check("lk_lock1", 32'(post_locked[a0 + 1]), 32'd1);
    check("lk_lock2", 32'(post_locked[a0 + 2]), 32'd0);
    check("lk_gid3",  32'(post_gid[a0 + 3]), 32'd0);

    // Busy timeout: transmitter never drops ready
    never_drop = 1'b1;
    do_reset(2);
    a0 = acc_cnt; r0 = rx_cnt;
    push(2, 1'b0, 8'h77);
    push(3, 1'b1, 8'h88);
    wait_ready_seen("to_accept_seen", 20);
    check("to_ready", 32'(req_ready), 32'b0100);
    first_err = -1; err_n = 0; lock_at = 1'bx;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (err_timeout) begin
        if (first_err < 0) begin
          first_err = k;
          lock_at = locked;
        end
        err_n++;
      end
    end
    check("to_first_err", 32'(first_err), 32'd17);
    check("to_err_width", 32'(err_n), 32'd1);
    check("to_lock_clear", 32'(lock_at), 32'd0);
    check("to_lock_held", 32'(post_locked[a0]), 32'd1);
    wait_acc("to_next", a0 + 2, 50);
    check("to_next_id", 32'(acc_log[a0 + 1]), 32'd3);
    wait_idle("to_idle", 100);
    check("to_next_rx", 32'(rx_log[r0 + 1]), 32'h88);
    never_drop = 1'b0;

    // Reset mid-frame while a lock is held
    frame_len = 50;
    do_reset(2);
    a0 = acc_cnt;
    push(1, 1'b0, 8'h31);
    wait_acc("mr_first", a0 + 1, 50);
    repeat (4) @(negedge clk);
    push(0, 1'b1, 8'h01);
    push(3, 1'b1, 8'h03);
    repeat (2) @(negedge clk);
    check("mr_stall_ready", 32'(req_ready), 32'h0);
    check("mr_locked_pre", 32'(locked), 32'd1);
    check("mr_busy_pre", 32'(busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_locked", 32'(locked), 32'd0);
    check("mr_valid", 32'(tx_input_data_valid), 32'd0);
    check("mr_prio0", 32'(req_ready), 32'b0001);
    wait_acc("mr_done", a0 + 3, 300);
    check("mr_ord1", 32'(acc_log[a0 + 1]), 32'd0);
    check("mr_ord2", 32'(acc_log[a0 + 2]), 32'd3);
    wait_idle("mr_idle", 200);

    check("ready_onehot_idle_only", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter among NUM_REQ byte requesters. It accepts one byte from the winning requester and presents it to the transmitter's tx_input_data / tx_input_data_valid interface. It waits for the frame to finish, tracked through tx_output_ready, and then arbitrates again. Optional message locking keeps the transmitter with one requester for a multi-byte message. It sits between client logic and uart_main's transmit side.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width; must match the transmitter
BUSY_TIMEOUT, 16, max cycles to wait for tx_output_ready to fall after a handoff

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  byte is the last of a message (1 = release lock)
req_ready  output  NUM_REQ  one-hot accept strobe; byte taken when req_valid[i] && req_ready[i]
tx_input_data  output  DATA_WIDTH  byte to transmitter (registered)
tx_input_data_valid  output  1  byte valid to transmitter (registered)
tx_output_ready  input  1  transmitter idle / able to accept
grant_id  output  clog2(NUM_REQ)  index of the requester last accepted
locked  output  1  message lock held by grant_id
busy  output  1  state != IDLE
err_timeout  output  1  one-cycle pulse when BUSY_TIMEOUT expires

Behaviour:
- Reset, and on the edge after rst is sampled high:
  - tx_input_data_valid=0, tx_input_data=0, req_ready=0, grant_id=0, locked=0, busy=0, err_timeout=0.
  - State goes to IDLE, the RR pointer is set so requester 0 has top priority, and the timeout counter is cleared.
  - rst mid-frame abandons the transfer; no req_ready is issued.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If not locked: the winner is the first i with req_valid[i]=1, scanning from (last winner+1) mod NUM_REQ upward with wrap.
  - If locked: the only candidate is grant_id. Other requesters stall even if valid.
  - req_ready[winner]=1 combinationally in IDLE when a candidate is valid. All other req_ready bits are 0. req_ready is never high outside IDLE.
  - On accept:
    - Latch req_data slice into tx_input_data and set grant_id=winner.
    - Set locked = ~req_last[winner].
    - Set tx_input_data_valid=1 and go to SEND.
    - Latency is 1 cycle from accept to valid.
- SEND: hold tx_input_data_valid and tx_input_data stable until tx_output_ready=1 is sampled. On that edge, set valid=0, clear the counter, and go to WAIT_BUSY.
- WAIT_BUSY:
  - On tx_output_ready=0, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT, pulse err_timeout for one cycle, clear locked, and go to IDLE.
- WAIT_DONE: on tx_output_ready=1, go to IDLE. There is no timeout here, because frame length is baud-dependent.
- The RR pointer updates only on unlocked accepts, and on the accept that releases the lock; the next search starts after that winner.
- Simultaneous requests from all requesters: grants rotate strictly, with no starvation.
- Lock held while the owner drops req_valid: the arbiter stays in IDLE and waits; nothing is granted to others.
- A requester that deasserts req_valid before req_ready is simply not accepted; there is no penalty.
- busy = (state != IDLE).

Test Plan:
- Reset and idle: rst for 3 cycles, no requests -> all outputs 0, state IDLE, tx_input_data_valid never rises.
- Single byte: req_valid[2]=1, req_data[2]=8'hDF, req_last[2]=1, with the transmitter model dropping ready 1 cycle after accept and raising it 1000 cycles later -> req_ready[2] pulses once, tx_input_data=8'hDF with valid 1 cycle later, grant_id=2, locked=0, busy until ready returns.
- Round robin: all four requesters valid continuously with bytes 8'h10..8'h13, last=1 -> accept order 0,1,2,3,0,..., each req_ready one cycle wide, never two set together.
- Lock: requester 1 sends 8'hA0 (last=0), 8'hA1 (last=0), 8'hBF (last=1) while requester 0 is valid throughout -> the three bytes go consecutively, with locked=1 between them; requester 0 is served next.
- Timeout: the transmitter model never drops tx_output_ready after a handoff -> err_timeout pulses exactly 16 cycles after leaving SEND, locked clears, the next request is accepted.
- Reset mid-frame: assert rst while in WAIT_DONE with a lock held -> next cycle in IDLE, locked=0, requester 0 has top priority.
